// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

    localparam int MD_ITER = 32;
    localparam logic [4:0] MD_CNT_LOAD = 5'(MD_ITER - 1);

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used both for operand magnitude and
// for restoring the sign of the product, quotient and remainder.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one shift-add or restoring-divide step per cycle, 32 steps
// FIX   | sign correction, HI/LO written at the end of this cycle
// DONE  | done pulse; may relaunch straight into CALC
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W = WIDTH;

    md_state_t     state, state_nxt;
    muldiv_op_t    op_e;
    logic          busy_nxt, done_nxt;
    logic          launch, idle_like, signed_op;
    logic [4:0]    cnt;
    logic          is_div, neg_lo, neg_hi, div0;
    logic [2*W-1:0] acc;
    logic [W-1:0]  opnd;
    logic [W-1:0]  rem;
    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    mul_sum;
    logic [W:0]    prem;
    logic [W:0]    div_diff;
    logic          div_ge;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]  q_fix, r_fix;
    logic          unused_bits;

    assign op_e      = muldiv_op_t'(op);
    assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign idle_like = (state == IDLE) || (state == DONE);
    assign launch    = start && idle_like;

    muldiv_signfix #(.W(W)) u_abs_a (.val(A), .neg(signed_op & A[W-1]), .res(a_mag));
    muldiv_signfix #(.W(W)) u_abs_b (.val(B), .neg(signed_op & B[W-1]), .res(b_mag));

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: acc[W-1:0] shifts dividend out / quotient in; acc[2W-1:W] keeps raw A.
    assign prem     = {rem, acc[W-1]};
    assign div_ge   = prem >= {1'b0, opnd};
    assign div_diff = prem - {1'b0, opnd};

    muldiv_signfix #(.W(2*W)) u_fix_p (.val(acc),        .neg(neg_lo), .res(prod_fix));
    muldiv_signfix #(.W(W))   u_fix_q (.val(acc[W-1:0]), .neg(neg_lo), .res(q_fix));
    muldiv_signfix #(.W(W))   u_fix_r (.val(rem),        .neg(neg_hi), .res(r_fix));

    assign unused_bits = div_diff[W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            rem    <= '0;
        end else if (launch) begin
            cnt    <= MD_CNT_LOAD;
            is_div <= op[1];
            neg_lo <= signed_op & (A[W-1] ^ B[W-1]);
            neg_hi <= signed_op & A[W-1];
            div0   <= (B == '0);
            rem    <= '0;
            if (op[1]) begin
                acc  <= {A, a_mag};
                opnd <= b_mag;
            end else begin
                acc  <= {{W{1'b0}}, b_mag};
                opnd <= a_mag;
            end
        end else if (state == CALC) begin
            cnt <= cnt - 5'd1;
            if (is_div) begin
                rem          <= div_ge ? div_diff[W-1:0] : prem[W-1:0];
                acc[W-1:0]   <= {acc[W-2:0], div_ge};
            end else begin
                acc <= {mul_sum, acc[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!is_div) begin
                hi <= prod_fix[2*W-1:W];
                lo <= prod_fix[W-1:0];
            end else if (div0) begin
                hi <= acc[2*W-1:W];
                lo <= '1;
            end else begin
                hi <= r_fix;
                lo <= q_fix;
            end
        end else if (idle_like) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed
// literal cases and randomized operations with noise while busy.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q, r;
        case (o)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: an accepted start makes the unit busy for 33 edges, then results land.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          m_started = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start) begin
                    {p_hi, p_lo} = ref_result(op, A, B);
                    m_left = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("busy", {63'h0, busy}, {63'h0, m_left > 0});
            check("done", {63'h0, done}, {63'h0, m_done});
            if (m_left == 0) begin
                check("hi", {32'h0, hi}, {32'h0, m_hi});
                check("lo", {32'h0, lo}, {32'h0, m_lo});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input bit noise, output int bcyc, output bit got);
        bcyc = 0;
        got  = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) bcyc++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                wdata = $urandom; A = $urandom; B = $urandom; op = 2'($urandom);
            end
            tick();
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_60");
        end
    endtask

    task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int  bc;
        bit  got;
        launch_op(o, a, b);
        wait_done(1'b0, bc, got);
        check({name, "_hi"}, {32'h0, hi}, {32'h0, ehi});
        check({name, "_lo"}, {32'h0, lo}, {32'h0, elo});
        check({name, "_busy_cycles"}, 64'(bc), 64'd33);
        check({name, "_done_busy"}, {62'h0, done, busy}, 64'd2);
    endtask

    initial begin
        int  bc;
        bit  got;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [31:0] corner [6];
        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7};

        tick(); tick(); tick();
        check("reset_state", {30'h0, busy, done, hi, lo}, 64'h0);
        reset = 1'b0;
        tick();

        run_lit("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_lit("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_lit("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_lit("divu_zero", 2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
        run_lit("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_lit("div_zero",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

        // start and MTHI while busy are ignored
        launch_op(2'b11, 32'd100, 32'd7);
        tick(); tick(); tick(); tick();
        op = 2'b01; A = 32'd2; B = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        wait_done(1'b0, bc, got);
        check("busy_ignore_hi", {32'h0, hi}, 64'd2);
        check("busy_ignore_lo", {32'h0, lo}, 64'd14);

        tick();
        hi_we = 1'b1; wdata = 32'h1234;
        tick();
        hi_we = 1'b0;
        check("mthi", {32'h0, hi}, 64'h1234);
        lo_we = 1'b1; wdata = 32'h5678;
        tick();
        lo_we = 1'b0;
        check("mtlo", {hi, lo}, 64'h00001234_00005678);
        check("mt_busy", {63'h0, busy}, 64'h0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both", {hi, lo}, 64'h0000A5A5_0000A5A5);

        // reset mid-operation
        launch_op(2'b01, 32'h12345, 32'h6789);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        check("midreset_state", {30'h0, busy, done, hi, lo}, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) check("midreset_no_done", {63'h0, done}, 64'h0);
        end
        run_lit("multu_6x7", 2'b01, 32'd6, 32'd7, 32'h0, 32'd42);

        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            launch_op(ro, ra, rb);
            wait_done(n[0], bc, got);
            check("rand_result", {hi, lo}, ref_result(ro, ra, rb));
            if ($urandom_range(0, 2) == 0) begin
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                wdata = $urandom;
                tick();
                hi_we = 1'b0; lo_we = 1'b0;
            end
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS execute stage, in parallel with the ALU.
- Consumes the same register-file operands A/B as the ALU and holds the architectural HI/LO registers.
- hi/lo feed the execute-stage result mux for MFHI/MFLO.
- Control stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only when not busy
op  input  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
A  input  32  operand rs (multiplicand / dividend)
B  input  32  operand rt (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  32  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have just been updated
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, internal counter and accumulators=0.
- States:
  - IDLE: wait for start.
  - CALC: 32 iterations.
  - FIX: sign correction and HI/LO writeback.
  - DONE: done=1 for one cycle.
- Transitions: IDLE/DONE -start-> CALC; CALC -count==0-> FIX; FIX -> DONE; DONE -> IDLE, or CALC if start.
- Launch: start sampled at edge 0 latches the operation. Signed ops latch |A| and |B| plus the result sign flags.
- Iteration:
  - Multiply: radix-2 shift-add, 64-bit product accumulator.
  - Divide: restoring algorithm, 33-bit partial remainder.
  - Counter loads 31 and decrements once per CALC cycle.
- Timing:
  - busy=1 from edge 0 through the FIX cycle (33 cycles).
  - hi/lo update at the edge ending FIX.
  - done=1 in the following cycle (edge 0 + 34 cycles) with busy=0.
  - hi/lo are stable and valid whenever busy=0.
- Multiply results: HI = product[63:32], LO = product[31:0]. MULT returns the two's-complement 64-bit product.
- Divide results: LO = quotient, HI = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU, B==0): HI = A unchanged, LO = 32'hFFFFFFFF, normal latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0 (wraps, no flag).
- start while busy: ignored; op and operands are not re-latched.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we when not busy: written at that edge. If start occurs on the same edge, the write still happens and is overwritten at FIX.
- hi_we and lo_we together: both written with wdata.
- Reset mid-operation: returns to IDLE on that edge, clears hi/lo, drops busy. No done pulse is produced.
- No combinational path from inputs to any output; all outputs are registered.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - md_state_t enum (IDLE, CALC, FIX, DONE)
  - constant MD_ITER = 32
- One sub-module: muldiv_signfix, a combinational abs/conditional-negate helper. Instantiated at operand entry and at the FIX stage for the quotient/remainder/product.

Test Plan:
- MULTU A=32'hFFFFFFFF B=32'hFFFFFFFF -> after 34 cycles done=1, hi=32'hFFFFFFFE, lo=32'h00000001; busy high exactly 33 cycles.
- MULT A=-3 B=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. DIV A=-7 B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU A=100 B=0 -> hi=32'h00000064, lo=32'hFFFFFFFF. DIV A=32'h80000000 B=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Issue DIVU 100/7, then pulse start with MULTU 2*3 at cycle 5, and hi_we=1 wdata=32'hDEAD at cycle 6 -> both ignored; final hi=2, lo=14.
- Idle: hi_we=1 wdata=32'h1234, then lo_we=1 wdata=32'h5678 -> hi=32'h1234, lo=32'h5678 next edge, busy stays 0.
- Start MULTU, assert reset at cycle 10 -> next edge busy=0, hi=lo=0, no done pulse; new MULTU 6*7 afterwards -> lo=42.
